// File: rtl/ahbl_arbiter_2m.sv
// ahbl_arbiter_2m: round-robin two-client AHB-Lite master with byte-lane formatting.
// Optional data-phase timeout abort enabled by defining AHBL_ARB_TIMEOUT_EN.
module ahbl_arbiter_2m #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        write0,
    input  logic        write1,
    input  logic [2:0]  size0,
    input  logic [2:0]  size1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
    state_t state, state_nxt;
    logic last_grant, gnt, pick, to;
    logic [2:0] size_sel;
    logic [31:0] wd_sel, wd_fmt, rd_fmt;
    logic [7:0] rd_b;
    logic [15:0] rd_h;
    assign pick = (req0 & req1) ? ~last_grant : req1;
    assign size_sel = pick ? size1 : size0;
    assign wd_sel = gnt ? wdata1 : wdata0;
    assign wd_fmt = HSIZE == 3'd0 ? {4{wd_sel[7:0]}} : HSIZE == 3'd1 ? {2{wd_sel[15:0]}} : wd_sel;
    assign rd_b = HRDATA[{HADDR[1:0], 3'b000} +: 8];
    assign rd_h = HRDATA[{HADDR[1], 4'b0000} +: 16];
    assign rd_fmt = HSIZE == 3'd0 ? {24'b0, rd_b} : HSIZE == 3'd1 ? {16'b0, rd_h} : HRDATA;
    always_ff @(posedge HCLK)
        state <= HRESET ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (req0 | req1) ? ADDR : IDLE;
            ADDR:    state_nxt = HREADY ? DATA : ADDR;
            DATA:    state_nxt = (HREADY | to) ? DONE : DATA;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            HADDR      <= '0;
            HTRANS     <= 2'b00;
            HSIZE      <= '0;
            HWRITE     <= 1'b0;
            HWDATA     <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: if (req0 | req1) begin
                    gnt        <= pick;
                    last_grant <= pick;
                    HADDR      <= pick ? addr1 : addr0;
                    HSIZE      <= size_sel > 3'd2 ? 3'd2 : size_sel;
                    HWRITE     <= pick ? write1 : write0;
                    HTRANS     <= 2'b10;
                end
                ADDR: if (HREADY) begin
                    HTRANS <= 2'b00;
                    HWDATA <= wd_fmt;
                end
                DATA: begin
                    if (HREADY | to) {ack1, ack0} <= gnt ? 2'b10 : 2'b01;
                    if (HREADY && !HWRITE && !gnt) rdata0 <= rd_fmt;
                    if (HREADY && !HWRITE && gnt) rdata1 <= rd_fmt;
                end
                default: ;
            endcase
        end
    end
`ifdef AHBL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt;
    // Abort fires on the TIMEOUT_CYCLES-th consecutive wait cycle of the data phase.
    assign to = state == DATA && !HREADY && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge HCLK) begin
        if (HRESET || state != DATA) cnt <= '0;
        else if (!HREADY) cnt <= cnt + CW'(1);
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) {err1, err0} <= 2'b00;
        else {err1, err0} <= to ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    end
`else
    assign to = 1'b0;
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif
endmodule

// File: tb/tb_ahbl_arbiter_2m.sv
// tb_ahbl_arbiter_2m: directed vector table plus hand sequences for ties, waits, reset and timeout.
module tb_ahbl_arbiter_2m;
    logic HCLK, HRESET, HREADY;
    logic [1:0] req, write, ack, err;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [2:0] size [2];
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0] HTRANS;
    logic [2:0] HSIZE;
    logic HWRITE;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        c;
        logic        w;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic [31:0] hr;
        logic [31:0] ehw;
        logic [31:0] erd;
        logic [2:0]  ehs;
    } vec_t;
    vec_t vecs [8];

    ahbl_arbiter_2m #(.TIMEOUT_CYCLES(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req0(req[0]), .req1(req[1]),
        .addr0(addr[0]), .addr1(addr[1]),
        .wdata0(wdata[0]), .wdata1(wdata[1]),
        .write0(write[0]), .write1(write[1]),
        .size0(size[0]), .size1(size[1]),
        .ack0(ack[0]), .ack1(ack[1]),
        .rdata0(rdata[0]), .rdata1(rdata[1]),
        .err0(err[0]), .err1(err[1]),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        req[v.c] = 1'b1;
        addr[v.c] = v.a;
        wdata[v.c] = v.wd;
        write[v.c] = v.w;
        size[v.c] = v.sz;
        HRDATA = v.hr;
        HREADY = 1'b1;
        @(negedge HCLK);
        chk("vec_htrans_nonseq", {30'b0, HTRANS}, 32'h2);
        chk("vec_haddr", HADDR, v.a);
        chk("vec_hsize", {29'b0, HSIZE}, {29'b0, v.ehs});
        chk("vec_hwrite", {31'b0, HWRITE}, {31'b0, v.w});
        @(negedge HCLK);
        chk("vec_htrans_idle", {30'b0, HTRANS}, 32'h0);
        chk("vec_hwdata", HWDATA, v.ehw);
        @(negedge HCLK);
        chk("vec_ack", {30'b0, ack}, v.c ? 32'h2 : 32'h1);
        chk("vec_rdata", rdata[v.c], v.erd);
        chk("vec_err", {30'b0, err}, 32'h0);
        req[v.c] = 1'b0;
        @(negedge HCLK);
        chk("vec_ack_clear", {30'b0, ack}, 32'h0);
    endtask

    task automatic tie(input logic f);
        req = 2'b11;
        write = 2'b11;
        addr[0] = 32'hA000_0000;
        addr[1] = 32'hB000_0000;
        wdata[0] = 32'h1111_1111;
        wdata[1] = 32'h2222_2222;
        size[0] = 3'd2;
        size[1] = 3'd2;
        HREADY = 1'b1;
        @(negedge HCLK);
        chk("tie_first_haddr", HADDR, f ? 32'hB000_0000 : 32'hA000_0000);
        @(negedge HCLK);
        chk("tie_first_hwdata", HWDATA, f ? 32'h2222_2222 : 32'h1111_1111);
        @(negedge HCLK);
        chk("tie_first_ack", {30'b0, ack}, f ? 32'h2 : 32'h1);
        req[f] = 1'b0;
        @(negedge HCLK);
        chk("tie_gap_ack", {30'b0, ack}, 32'h0);
        @(negedge HCLK);
        chk("tie_second_haddr", HADDR, f ? 32'hA000_0000 : 32'hB000_0000);
        chk("tie_second_htrans", {30'b0, HTRANS}, 32'h2);
        @(negedge HCLK);
        @(negedge HCLK);
        chk("tie_second_ack", {30'b0, ack}, f ? 32'h1 : 32'h2);
        req[!f] = 1'b0;
        @(negedge HCLK);
        chk("tie_end_ack", {30'b0, ack}, 32'h0);
    endtask

    initial begin
        int first;
        int nack;
        logic err_seen;
        logic [31:0] rd_at_ack;
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0000, 3'd2, 32'h1234_5670, 32'hDEAD_BEEF, 32'h1234_5670, 32'h0000_0000, 3'd2};
        vecs[1] = '{1'b1, 1'b0, 32'h4000_0003, 3'd0, 32'h0000_0000, 32'hAABB_CCDD, 32'h0000_0000, 32'h0000_00AA, 3'd0};
        vecs[2] = '{1'b1, 1'b0, 32'h4000_0002, 3'd1, 32'h0000_0000, 32'hAABB_CCDD, 32'h0000_0000, 32'h0000_AABB, 3'd1};
        vecs[3] = '{1'b0, 1'b0, 32'h1000_0001, 3'd0, 32'h0000_0099, 32'hAABB_CCDD, 32'h9999_9999, 32'h0000_00CC, 3'd0};
        vecs[4] = '{1'b0, 1'b1, 32'h2000_0002, 3'd1, 32'hFFFF_5A3C, 32'h0000_0000, 32'h5A3C_5A3C, 32'h0000_00CC, 3'd1};
        vecs[5] = '{1'b1, 1'b1, 32'h3000_0001, 3'd0, 32'h1234_56E7, 32'h0000_0000, 32'hE7E7_E7E7, 32'h0000_AABB, 3'd0};
        vecs[6] = '{1'b1, 1'b0, 32'h6000_0000, 3'd1, 32'h0000_1234, 32'hAABB_CCDD, 32'h1234_1234, 32'h0000_CCDD, 3'd1};
        vecs[7] = '{1'b0, 1'b0, 32'h5000_0000, 3'd7, 32'h89AB_CDEF, 32'h0102_0304, 32'h89AB_CDEF, 32'h0102_0304, 3'd2};
        HRESET = 1'b1;
        HREADY = 1'b1;
        HRDATA = '0;
        req = '0;
        write = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0;
            wdata[i] = '0;
            size[i] = '0;
        end
        repeat (3) @(negedge HCLK);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_htrans", {30'b0, HTRANS}, 32'h0);
        chk("rst_hsize", {29'b0, HSIZE}, 32'h0);
        chk("rst_hwrite", {31'b0, HWRITE}, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_ack_err", {28'b0, ack, err}, 32'h0);
        chk("rst_rdata0", rdata[0], 32'h0);
        chk("rst_rdata1", rdata[1], 32'h0);
        HRESET = 1'b0;
        tie(1'b0);
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        tie(1'b1);
        // Wait states: two in the address phase, three in the data phase.
        req[1] = 1'b1;
        addr[1] = 32'h9000_0008;
        write[1] = 1'b0;
        size[1] = 3'd2;
        wdata[1] = 32'h0BAD_BEEF;
        HRDATA = 32'hCAFE_F00D;
        HREADY = 1'b1;
        @(negedge HCLK);
        chk("ws_nonseq", {30'b0, HTRANS}, 32'h2);
        HREADY = 1'b0;
        repeat (2) begin
            @(negedge HCLK);
            chk("ws_addr_htrans_hold", {30'b0, HTRANS}, 32'h2);
            chk("ws_addr_haddr_hold", HADDR, 32'h9000_0008);
        end
        HREADY = 1'b1;
        @(negedge HCLK);
        chk("ws_data_htrans", {30'b0, HTRANS}, 32'h0);
        chk("ws_data_hwdata", HWDATA, 32'h0BAD_BEEF);
        HREADY = 1'b0;
        repeat (3) begin
            @(negedge HCLK);
            chk("ws_data_no_ack", {30'b0, ack}, 32'h0);
            chk("ws_data_hwdata_hold", HWDATA, 32'h0BAD_BEEF);
        end
        HREADY = 1'b1;
        @(negedge HCLK);
        chk("ws_ack", {30'b0, ack}, 32'h2);
        chk("ws_rdata", rdata[1], 32'hCAFE_F00D);
        req[1] = 1'b0;
        @(negedge HCLK);
        chk("ws_ack_clear", {30'b0, ack}, 32'h0);
        // Reset while stalled in the data phase.
        req[0] = 1'b1;
        addr[0] = 32'h7000_0004;
        write[0] = 1'b0;
        size[0] = 3'd2;
        HRDATA = 32'h1357_9BDF;
        @(negedge HCLK);
        @(negedge HCLK);
        HREADY = 1'b0;
        @(negedge HCLK);
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("rmid_htrans", {30'b0, HTRANS}, 32'h0);
        chk("rmid_ack", {30'b0, ack}, 32'h0);
        chk("rmid_haddr", HADDR, 32'h0);
        chk("rmid_rdata0", rdata[0], 32'h0);
        HRESET = 1'b0;
        req[0] = 1'b0;
        HREADY = 1'b1;
        @(negedge HCLK);
        run_vec(vecs[0]);
        // Data phase never completes.
        req[0] = 1'b1;
        addr[0] = 32'h8000_0000;
        write[0] = 1'b0;
        size[0] = 3'd2;
        HRDATA = 32'h5555_AAAA;
        HREADY = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);
        HREADY = 1'b0;
        first = 0;
        nack = 0;
        err_seen = 1'b0;
        rd_at_ack = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge HCLK);
            if (ack[0]) begin
                nack++;
                if (first == 0) begin
                    first = i;
                    err_seen = err[0];
                    rd_at_ack = rdata[0];
                end
                req[0] = 1'b0;
            end
        end
`ifdef AHBL_ARB_TIMEOUT_EN
        chk("to_ack_count", nack, 1);
        chk("to_wait_cycles", first, 16);
        chk("to_err0", {31'b0, err_seen}, 32'h1);
        chk("to_rdata_unchanged", rd_at_ack, 32'h0);
`else
        chk("to_no_ack", nack, 0);
        chk("to_no_err", {30'b0, err}, 32'h0);
`endif
        HRESET = 1'b1;
        req = '0;
        HREADY = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ahbl_arbiter_2m.md
# ahbl_arbiter_2m

Two-requester AHB-Lite master controller that shares a single AHB-Lite master port between two internal clients. Each client issues a single-transfer command through a req/ack handshake. The block arbitrates between clients round-robin and sequences the non-pipelined address phase and data phase on the bus, honouring HREADY. It performs byte-lane formatting for write data and read data. It sits between client engines (test sequencers, DMA, CPU shims) and the AHB-Lite decoder/slave fabric.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: maximum data-phase wait cycles before abort. Used only with AHBL_ARB_TIMEOUT_EN.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- req0, req1  in  1  client command request; held high until ack.
- addr0, addr1  in  32  byte address.
- wdata0, wdata1  in  32  write data, right-justified.
- write0, write1  in  1  1 = write, 0 = read.
- size0, size1  in  3  0 = byte, 1 = halfword, 2 = word; values greater than 2 are treated as 2.
- ack0, ack1  out  1  one-cycle completion pulse.
- rdata0, rdata1  out  32  right-justified, zero-extended read data; valid while ack is high.
- err0, err1  out  1  timeout abort flag; valid while ack is high.
- HADDR  out  32, HTRANS  out  2, HSIZE  out  3, HWRITE  out  1, HWDATA  out  32: AHB-Lite master outputs.
- HREADY  in  1, HRDATA  in  32: AHB-Lite returns.

## Operation
- All outputs are registered.
- FSM states are IDLE, ADDR, DATA and DONE.
- **IDLE**
  - If any req is high, grant one client and load HADDR, HSIZE (clamped) and HWRITE from that client.
  - Set HTRANS to 2'b10 (NONSEQ) and go to ADDR.
- **Arbitration:** a single requester wins. If both request, the client opposite last_grant wins. last_grant updates on each grant.
- **ADDR**
  - With HREADY=1: set HTRANS to 2'b00, load HWDATA with the formatted write data (reads also load it, harmlessly), and go to DATA.
  - With HREADY=0: hold all outputs.
- **DATA**
  - With HREADY=1: capture formatted HRDATA into the granted client's rdata (reads only; writes leave rdata unchanged), pulse that client's ack, and go to DONE.
  - With HREADY=0: remain in DATA.
- **DONE**
  - Ack is high for this one cycle. The client drops req in this cycle.
  - Go unconditionally to IDLE. req is not sampled in DONE, so no duplicate transfer is possible.
- **Write formatting:**
  - Byte: wdata[7:0] replicated on all 4 lanes.
  - Halfword: wdata[15:0] replicated on both halves.
  - Word: passed through.
- **Read formatting:**
  - Byte: HRDATA[8*addr[1:0] +: 8], zero-extended.
  - Halfword: HRDATA[16*addr[1] +: 16], zero-extended.
  - Word: HRDATA unchanged.
- **Alignment:** misaligned addresses are not checked. The low address bits pass to HADDR unchanged.
- **Changing inputs:** a client changing its fields while granted is unsupported. The fields are sampled only in IDLE (address/control) and ADDR (wdata).

## Timing
- **Reset values:**
  - HADDR=0, HTRANS=2'b00, HSIZE=0, HWRITE=0, HWDATA=0.
  - ack*=0, rdata*=0, err*=0.
  - state=IDLE, last_grant=1, so client 0 wins the first tie.
- **Zero-wait latency:** req sampled at edge E0 gives NONSEQ after E0, address accepted at E1, data completed at E2. Ack is high in the cycle after E2.
- **Throughput:** one transfer per 4 cycles. Each HREADY-low cycle in ADDR or DATA adds 1 cycle.
- **Simultaneous requests in IDLE:** exactly one grant. The loser is served next, so no client waits more than one transfer.
- **Reset mid-transfer:** HRESET at any edge forces all reset values at that edge. There is no ack or err for the abandoned transfer, and HTRANS returns to 2'b00 immediately.
- **Request withdrawn:** req dropped while granted is ignored; the transfer completes and still acks.

## Configuration
- **AHBL_ARB_TIMEOUT_EN defined:**
  - An 8-bit or larger wait counter clears on entry to DATA and increments on each HREADY=0 cycle in DATA.
  - When it reaches TIMEOUT_CYCLES with HREADY still 0, go to DONE with ack=1, err=1 and rdata unchanged.
  - HTRANS is already IDLE at that point. This is a bring-up aid, not AHB-compliant recovery.
- **Not defined:** no counter. DATA waits indefinitely and err0/err1 are tied to 0.

## Test plan
- **Single write:** client 0 writes 0x12345670 to 0x00000000 with size 2 and HREADY always 1 -> NONSEQ for 1 cycle, HWDATA=0x12345670 in the data phase, ack0 in the 4th cycle after req.
- **Contention:** req0 and req1 rise on the same edge after reset -> client 0 granted first, client 1 next, each acked once. A repeated tie grants client 1 first.
- **Byte read lanes:** client 1 reads size 0 at 0x40000003 with HRDATA=0xAABBCCDD -> rdata1=0x000000AA. Halfword at 0x40000002 -> rdata1=0x0000AABB.
- **Wait states:** HREADY low 2 cycles in ADDR and 3 cycles in DATA -> outputs stable throughout, ack after 4+5 cycles.
- **Reset mid-transfer:** HRESET asserted during DATA -> HTRANS=0 and ack=0 next cycle; a new req after reset is served normally.
- **Timeout (AHBL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16):** HREADY held low in DATA -> ack0=1 and err0=1 after 16 wait cycles. Without the macro, no ack ever.
